tlb_refill_ctrl: RTL and testbench

//  Miss handler and flush sequencer for the 8-entry fully-associative TLB.
//  On a lookup miss it walks the two-level x86 page table through a memory read port.
//  It then writes the resulting entry into the TLB entry array, choosing the slot round-robin.
//  It also invalidates all 8 entries on request. Sits between the TLB match logic, the

---
 rtl/tlb_refill_ctrl.sv | 150 +++++++++++++++
 tb/tb_tlb_refill_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill_ctrl.sv
// TLB miss handler: two-level x86 page walk, round-robin refill
// and full-array flush sequencer for the 8-entry TLB.
module tlb_refill_ctrl #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           MISS_REQ,
    input  logic [19:0]                    MISS_VPN,
    input  logic                           FLUSH_REQ,
    input  logic [19:0]                    PDBR,
    output logic                           MEM_RD_REQ,
    output logic [31:0]                    MEM_RD_ADDR,
    input  logic                           MEM_RD_ACK,
    input  logic [31:0]                    MEM_RD_DATA,
    output logic                           TLB_WR_EN,
    output logic [$clog2(NUM_ENTRIES)-1:0] TLB_WR_IDX,
    output logic [43:0]                    TLB_WR_DATA,
    output logic                           BUSY,
    output logic                           MISS_DONE,
    output logic                           PAGE_FAULT,
    output logic                           FLUSH_DONE
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PDE,
        S_PTE,
        S_FILL,
        S_FAULT,
        S_FLUSH
    } state_t;

    state_t           state;
    logic [19:0]      vpn;
    logic             pde_rw;
    logic             pde_pcd;
    logic [IDX_W-1:0] victim;
    logic [IDX_W-1:0] cnt;

    // Flag/reserved PDE/PTE bits play no part in the cached entry.
    logic unused_data;
    assign unused_data = ^{MEM_RD_DATA[11:5], MEM_RD_DATA[3:2]};

    // Walk/flush FSM; every output is registered alongside the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            vpn         <= '0;
            pde_rw      <= 1'b0;
            pde_pcd     <= 1'b0;
            victim      <= '0;
            cnt         <= '0;
            MEM_RD_REQ  <= 1'b0;
            MEM_RD_ADDR <= '0;
            TLB_WR_EN   <= 1'b0;
            TLB_WR_IDX  <= '0;
            TLB_WR_DATA <= '0;
            BUSY        <= 1'b0;
            MISS_DONE   <= 1'b0;
            PAGE_FAULT  <= 1'b0;
            FLUSH_DONE  <= 1'b0;
        end else begin
            TLB_WR_EN  <= 1'b0;
            MISS_DONE  <= 1'b0;
            PAGE_FAULT <= 1'b0;
            FLUSH_DONE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (FLUSH_REQ) begin
                        state       <= S_FLUSH;
                        cnt         <= '0;
                        BUSY        <= 1'b1;
                        TLB_WR_EN   <= 1'b1;
                        TLB_WR_IDX  <= '0;
                        TLB_WR_DATA <= '0;
                    end else if (MISS_REQ) begin
                        state       <= S_PDE;
                        vpn         <= MISS_VPN;
                        BUSY        <= 1'b1;
                        MEM_RD_REQ  <= 1'b1;
                        MEM_RD_ADDR <= {PDBR, MISS_VPN[19:10], 2'b00};
                    end
                end
                S_PDE: begin
                    if (MEM_RD_ACK) begin
                        pde_rw  <= MEM_RD_DATA[1];
                        pde_pcd <= MEM_RD_DATA[4];
                        if (!MEM_RD_DATA[0]) begin
                            state      <= S_FAULT;
                            MEM_RD_REQ <= 1'b0;
                            PAGE_FAULT <= 1'b1;
                        end else begin
                            state       <= S_PTE;
                            MEM_RD_ADDR <= {MEM_RD_DATA[31:12], vpn[9:0], 2'b00};
                        end
                    end
                end
                S_PTE: begin
                    if (MEM_RD_ACK) begin
                        MEM_RD_REQ <= 1'b0;
                        if (!MEM_RD_DATA[0]) begin
                            state      <= S_FAULT;
                            PAGE_FAULT <= 1'b1;
                        end else begin
                            state       <= S_FILL;
                            TLB_WR_EN   <= 1'b1;
                            MISS_DONE   <= 1'b1;
                            TLB_WR_IDX  <= victim;
                            TLB_WR_DATA <= {vpn, MEM_RD_DATA[31:12], 2'b11,
                                            pde_rw & MEM_RD_DATA[1],
                                            pde_pcd | MEM_RD_DATA[4]};
                        end
                    end
                end
                S_FILL: begin
                    state  <= S_IDLE;
                    BUSY   <= 1'b0;
                    victim <= victim + 1'b1;
                end
                S_FAULT: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                S_FLUSH: begin
                    if (cnt == LAST_IDX) begin
                        state  <= S_IDLE;
                        BUSY   <= 1'b0;
                        victim <= '0;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        TLB_WR_EN   <= 1'b1;
                        TLB_WR_IDX  <= cnt + 1'b1;
                        TLB_WR_DATA <= '0;
                        FLUSH_DONE  <= ((cnt + 1'b1) == LAST_IDX);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    BUSY       <= 1'b0;
                    MEM_RD_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl: walks, faults, wrap,
// flush priority and mid-walk reset.
module tb_tlb_refill_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MISS_REQ = 1'b0;
    logic [19:0] MISS_VPN = '0;
    logic        FLUSH_REQ = 1'b0;
    logic [19:0] PDBR = '0;
    logic        MEM_RD_REQ;
    logic [31:0] MEM_RD_ADDR;
    logic        MEM_RD_ACK = 1'b0;
    logic [31:0] MEM_RD_DATA = '0;
    logic        TLB_WR_EN;
    logic [2:0]  TLB_WR_IDX;
    logic [43:0] TLB_WR_DATA;
    logic        BUSY;
    logic        MISS_DONE;
    logic        PAGE_FAULT;
    logic        FLUSH_DONE;

    int vectors = 0;
    int miscompares = 0;

    tlb_refill_ctrl #(.NUM_ENTRIES(8)) dut (
        .CLK(CLK), .RST(RST),
        .MISS_REQ(MISS_REQ), .MISS_VPN(MISS_VPN),
        .FLUSH_REQ(FLUSH_REQ), .PDBR(PDBR),
        .MEM_RD_REQ(MEM_RD_REQ), .MEM_RD_ADDR(MEM_RD_ADDR),
        .MEM_RD_ACK(MEM_RD_ACK), .MEM_RD_DATA(MEM_RD_DATA),
        .TLB_WR_EN(TLB_WR_EN), .TLB_WR_IDX(TLB_WR_IDX),
        .TLB_WR_DATA(TLB_WR_DATA), .BUSY(BUSY),
        .MISS_DONE(MISS_DONE), .PAGE_FAULT(PAGE_FAULT),
        .FLUSH_DONE(FLUSH_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Full miss with configurable ACK latencies; checks every cycle.
    task automatic do_miss(input string nm, input logic [19:0] vpn,
                           input logic [19:0] pdbr, input logic [31:0] pde,
                           input logic [31:0] pte, input int pde_lat,
                           input int pte_lat, input logic [2:0] exp_idx);
        logic [31:0] a_pde;
        logic [31:0] a_pte;
        logic [43:0] e_dat;
        a_pde = {pdbr, vpn[19:10], 2'b00};
        a_pte = {pde[31:12], vpn[9:0], 2'b00};
        e_dat = {vpn, pte[31:12], 2'b11, pde[1] & pte[1], pde[4] | pte[4]};
        MISS_REQ = 1'b1; MISS_VPN = vpn; PDBR = pdbr;
        step();
        MISS_REQ = 1'b0;
        for (int i = 0; i <= pde_lat; i++) begin
            vectors++;
            if (MEM_RD_REQ !== 1'b1 || MEM_RD_ADDR !== a_pde || BUSY !== 1'b1) begin
                miscompares++;
                $display("FAIL %s pde_req c%0d: req=%b addr=%h busy=%b want req=1 addr=%h busy=1",
                         nm, i, MEM_RD_REQ, MEM_RD_ADDR, BUSY, a_pde);
            end
            if (i < pde_lat) step();
        end
        MEM_RD_ACK = 1'b1; MEM_RD_DATA = pde;
        step();
        MEM_RD_ACK = 1'b0; MEM_RD_DATA = '0;
        if (pde[0]) begin
            for (int i = 0; i <= pte_lat; i++) begin
                vectors++;
                if (MEM_RD_REQ !== 1'b1 || MEM_RD_ADDR !== a_pte) begin
                    miscompares++;
                    $display("FAIL %s pte_req c%0d: req=%b addr=%h want req=1 addr=%h",
                             nm, i, MEM_RD_REQ, MEM_RD_ADDR, a_pte);
                end
                if (i < pte_lat) step();
            end
            MEM_RD_ACK = 1'b1; MEM_RD_DATA = pte;
            step();
            MEM_RD_ACK = 1'b0; MEM_RD_DATA = '0;
        end
        if (pde[0] && pte[0]) begin
            vectors++;
            if (TLB_WR_EN !== 1'b1 || MISS_DONE !== 1'b1 || TLB_WR_IDX !== exp_idx ||
                TLB_WR_DATA !== e_dat || MEM_RD_REQ !== 1'b0 || PAGE_FAULT !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fill: en=%b done=%b idx=%0d data=%h req=%b pf=%b want 1 1 %0d %h 0 0",
                         nm, TLB_WR_EN, MISS_DONE, TLB_WR_IDX, TLB_WR_DATA,
                         MEM_RD_REQ, PAGE_FAULT, exp_idx, e_dat);
            end
        end else begin
            vectors++;
            if (PAGE_FAULT !== 1'b1 || TLB_WR_EN !== 1'b0 || MISS_DONE !== 1'b0 ||
                MEM_RD_REQ !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fault: pf=%b en=%b done=%b req=%b want 1 0 0 0",
                         nm, PAGE_FAULT, TLB_WR_EN, MISS_DONE, MEM_RD_REQ);
            end
        end
        step();
        vectors++;
        if (BUSY !== 1'b0 || TLB_WR_EN !== 1'b0 || PAGE_FAULT !== 1'b0 ||
            MISS_DONE !== 1'b0 || MEM_RD_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: busy=%b en=%b pf=%b done=%b req=%b want all 0",
                     nm, BUSY, TLB_WR_EN, PAGE_FAULT, MISS_DONE, MEM_RD_REQ);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) step();
        vectors++;
        if ({MEM_RD_REQ, TLB_WR_EN, BUSY, MISS_DONE, PAGE_FAULT, FLUSH_DONE} !== 6'b0 ||
            MEM_RD_ADDR !== 32'h0 || TLB_WR_IDX !== 3'd0 || TLB_WR_DATA !== 44'h0) begin
            miscompares++;
            $display("FAIL reset_outs: flags=%b addr=%h idx=%0d data=%h want all 0",
                     {MEM_RD_REQ, TLB_WR_EN, BUSY, MISS_DONE, PAGE_FAULT, FLUSH_DONE},
                     MEM_RD_ADDR, TLB_WR_IDX, TLB_WR_DATA);
        end
        @(negedge CLK);
        RST = 1'b1;
        step();
        vectors++;
        if (BUSY !== 1'b0 || MEM_RD_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b req=%b want 0 0", BUSY, MEM_RD_REQ);
        end
    endtask

    task automatic test_basic_walk();
        // PDE addr = {00010, 10'h02C, 00} = 0x000100B0; PTE addr = 0x00020000.
        do_miss("basic", 20'h0b000, 20'h00010, 32'h00020003, 32'h00004003, 0, 0, 3'd0);
        vectors++;
        if (44'({20'h0b000, 20'h00004, 4'b1110}) !== dut.TLB_WR_DATA) begin
            miscompares++;
            $display("FAIL basic_data_hold: data=%h want %h", TLB_WR_DATA,
                     {20'h0b000, 20'h00004, 4'b1110});
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int k = 0; k < 9; k++) begin
            do_miss("wrap", 20'h12345 + 20'(k), 20'h00100, 32'h00123013,
                    32'h0ABCD001 + 32'(k << 12), 0, 0, 3'(k % 8));
        end
    endtask

    task automatic test_pde_fault();
        do_miss("pde_fault", 20'h00400, 20'h00200, 32'h00000000, 32'h0, 1, 0, 3'd1);
        do_miss("after_pde_fault", 20'h00401, 20'h00200, 32'h00055007,
                32'h00066011, 0, 0, 3'd1);
    endtask

    task automatic test_pte_fault_late();
        do_miss("pte_fault_late", 20'hFFFFF, 20'h00300, 32'h00077001,
                32'h00088002, 0, 3, 3'd2);
        do_miss("after_pte_fault", 20'h00002, 20'h00300, 32'h00077003,
                32'h00099003, 2, 1, 3'd2);
    endtask

    task automatic test_flush_priority();
        FLUSH_REQ = 1'b1; MISS_REQ = 1'b1;
        MISS_VPN = 20'h0AAAA; PDBR = 20'h00500;
        step();
        FLUSH_REQ = 1'b0; MISS_REQ = 1'b0;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (TLB_WR_EN !== 1'b1 || TLB_WR_IDX !== 3'(k) || TLB_WR_DATA !== 44'h0 ||
                FLUSH_DONE !== (k == 7) || MEM_RD_REQ !== 1'b0 || BUSY !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_w%0d: en=%b idx=%0d data=%h fd=%b req=%b busy=%b want 1 %0d 0 %b 0 1",
                         k, TLB_WR_EN, TLB_WR_IDX, TLB_WR_DATA, FLUSH_DONE,
                         MEM_RD_REQ, BUSY, k, (k == 7));
            end
            if (k == 3) MISS_REQ = 1'b1;
            step();
            MISS_REQ = 1'b0;
        end
        vectors++;
        if (TLB_WR_EN !== 1'b0 || BUSY !== 1'b0 || FLUSH_DONE !== 1'b0 || MEM_RD_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_end: en=%b busy=%b fd=%b req=%b want 0 0 0 0",
                     TLB_WR_EN, BUSY, FLUSH_DONE, MEM_RD_REQ);
        end
        do_miss("after_flush", 20'h00ABC, 20'h00600, 32'h00010001,
                32'h00020013, 0, 0, 3'd0);
    endtask

    task automatic test_reset_mid_walk();
        MISS_REQ = 1'b1; MISS_VPN = 20'h33333; PDBR = 20'h00700;
        step();
        MISS_REQ = 1'b0;
        MEM_RD_ACK = 1'b1; MEM_RD_DATA = 32'h00044001;
        step();
        MEM_RD_ACK = 1'b0; MEM_RD_DATA = '0;
        step();
        vectors++;
        if (MEM_RD_REQ !== 1'b1 || MEM_RD_ADDR !== 32'h00044CCC) begin
            miscompares++;
            $display("FAIL rst_walk_pte: req=%b addr=%h want 1 00044ccc", MEM_RD_REQ, MEM_RD_ADDR);
        end
        #2 RST = 1'b0;
        #1;
        vectors++;
        if (MEM_RD_REQ !== 1'b0 || BUSY !== 1'b0 || TLB_WR_EN !== 1'b0 ||
            MEM_RD_ADDR !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_async: req=%b busy=%b en=%b addr=%h want 0 0 0 0",
                     MEM_RD_REQ, BUSY, TLB_WR_EN, MEM_RD_ADDR);
        end
        @(negedge CLK);
        RST = 1'b1;
        step();
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release_busy: busy=%b want 0", BUSY);
        end
        do_miss("after_rst", 20'h00010, 20'h00800, 32'h00011003,
                32'h00022003, 0, 0, 3'd0);
    endtask

    initial begin
        test_reset();
        test_basic_walk();
        test_wrap();
        test_pde_fault();
        test_pte_fault_late();
        test_flush_priority();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
